ex_mem: RTL and testbench
=========================

// Module: ex_mem
// PURPOSE
//  Pipeline register between the EX stage and the MEM stage. Captures EX results
//  (GPR writeback, HI/LO writeback) on each clock, honours the central stall vector,
//  inserts bubbles, and supports a synchronous flush. Also carries the partial
//  64-bit HI/LO accumulator and cycle count back to EX, so two-cycle MADD/MADDU/MSUB/MSUBU
//  can keep their progress across EX stalls.
// PARAMETERS
//  DATA_W   32  width of GPR/HI/LO data
//  ADDR_W   5   width of GPR destination address
//  STALL_W  6   width of stall vector (pc,if,id,ex,mem,wb)
//  EX_IDX   3   stall-vector bit for EX stage
//  MEM_IDX  4   stall-vector bit for MEM stage
// PORTS
//  clk        in   1          system clock, all state updates on rising edge
//  rst        in   1          synchronous, active-high reset
//  stall      in   STALL_W    stall request vector from ctrl
//  flush      in   1          synchronous pipeline flush (exception)
//  ex_wd      in   ADDR_W     EX destination GPR
//  ex_wreg    in   1          EX GPR write enable
//  ex_wdata   in   DATA_W     EX GPR write data
//  ex_hi      in   DATA_W     EX HI result
//  ex_lo      in   DATA_W     EX LO result
//  ex_whilo   in   1          EX HI/LO write enable
//  hilo_i     in   2*DATA_W   partial accumulator from EX (MADD/MSUB first cycle)
//  cnt_i      in   2          EX multi-cycle step counter
//  mem_wd     out  ADDR_W     registered destination GPR to MEM
//  mem_wreg   out  1          registered GPR write enable
//  mem_wdata  out  DATA_W     registered GPR write data
//  mem_hi     out  DATA_W     registered HI
//  mem_lo     out  DATA_W     registered LO
//  mem_whilo  out  1          registered HI/LO write enable
//  hilo_o     out  2*DATA_W   accumulator returned to EX
//  cnt_o      out  2          step counter returned to EX
// BEHAVIOUR
//  - Every output is a flop; there is no combinational path from input to output. Latency is 1 cycle.
//  - Priority at each rising edge, highest first:
//  1 rst=1: every output <= 0 (mem_wd=0, mem_wreg=0, mem_wdata=0, mem_hi/lo=0,
//      mem_whilo=0, hilo_o=0, cnt_o=0).
//  2 flush=1: same values as reset, regardless of stall. A flush discards
//      multi-cycle progress.
//  3 stall[EX_IDX]=1 & stall[MEM_IDX]=0 (bubble): mem_wd/wreg/wdata/hi/lo/whilo <= 0;
//      hilo_o <= hilo_i; cnt_o <= cnt_i.
//  4 stall[EX_IDX]=0 (advance): mem_* <= ex_*; hilo_o <= 0; cnt_o <= 0.
//  5 stall[EX_IDX]=1 & stall[MEM_IDX]=1 (hold): mem_* keep their values;
//      hilo_o <= hilo_i; cnt_o <= cnt_i.
//  - Case 4 also covers the illegal combination stall[EX_IDX]=0 & stall[MEM_IDX]=1:
//      the block advances, and a bench assertion flags the combination as a ctrl error.
//  - cnt_o is not incremented or decoded here. It is passed through unchanged,
//      and value 2'b11 passes through unchanged.
//  - Bits of stall other than EX_IDX and MEM_IDX are ignored.
//  - Reset or flush asserted mid-MADD (cnt_i=1) clears cnt_o on that edge. EX then restarts.
// TESTING
//  T1 advance: stall=0, ex_wd=3, ex_wreg=1, ex_wdata=32'h12345678, ex_whilo=1,
//     ex_hi=32'hA, ex_lo=32'hB -> next edge mem_* equal those values, cnt_o=0, hilo_o=0.
//  T2 bubble: stall=6'b001111, ex_wreg=1, hilo_i=64'h1_00000002, cnt_i=1 ->
//     mem_wreg=0, mem_wdata=0, mem_whilo=0, hilo_o=64'h1_00000002, cnt_o=1.
//  T3 hold: load T1 values, then stall=6'b011111 for 3 cycles with changing ex_* ->
//     mem_* stay 3/1/32'h12345678 every cycle; cnt_o tracks cnt_i.
//  T4 MADD release: T2 for 1 cycle, then stall=0 with ex_wdata=32'h55 -> cnt_o=0,
//     hilo_o=0, mem_wdata=32'h55.
//  T5 flush while held: T3 state, flush=1 with stall=6'b011111 -> all outputs 0 next edge.
//  T6 reset mid-op: ex_wdata=32'hDEADBEEF captured, rst=1 for 1 cycle -> all outputs 0;
//     rst=0 with stall=0 -> capture resumes on the following edge.

Source files
------------

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: captures EX results, inserts bubbles on stall,
// and returns the partial MADD/MSUB accumulator and step count to EX.
module ex_mem #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 6,
  parameter int EX_IDX  = 3,
  parameter int MEM_IDX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic                ex_whilo,
  input  logic [2*DATA_W-1:0] hilo_i,
  input  logic [1:0]          cnt_i,
  output logic [ADDR_W-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_whilo,
  output logic [2*DATA_W-1:0] hilo_o,
  output logic [1:0]          cnt_o
);

  logic [ADDR_W-1:0]   wd_d, wd_q;
  logic                wreg_d, wreg_q;
  logic [DATA_W-1:0]   wdata_d, wdata_q;
  logic [DATA_W-1:0]   hi_d, hi_q;
  logic [DATA_W-1:0]   lo_d, lo_q;
  logic                whilo_d, whilo_q;
  logic [2*DATA_W-1:0] hilo_d, hilo_q;
  logic [1:0]          cnt_d, cnt_q;

  logic ex_stall;
  logic mem_stall;
  logic unused_stall;

  assign ex_stall     = stall[EX_IDX];
  assign mem_stall    = stall[MEM_IDX];
  assign unused_stall = ^stall;

  always_comb begin
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    whilo_d = whilo_q;
    hilo_d  = '0;
    cnt_d   = '0;
    if (flush) begin
      wd_d    = '0;
      wreg_d  = 1'b0;
      wdata_d = '0;
      hi_d    = '0;
      lo_d    = '0;
      whilo_d = 1'b0;
    end else if (!ex_stall) begin
      wd_d    = ex_wd;
      wreg_d  = ex_wreg;
      wdata_d = ex_wdata;
      hi_d    = ex_hi;
      lo_d    = ex_lo;
      whilo_d = ex_whilo;
    end else begin
      // EX is stalled: keep multi-cycle progress alive
      hilo_d = hilo_i;
      cnt_d  = cnt_i;
      if (!mem_stall) begin
        wd_d    = '0;
        wreg_d  = 1'b0;
        wdata_d = '0;
        hi_d    = '0;
        lo_d    = '0;
        whilo_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      whilo_q <= 1'b0;
      hilo_q  <= '0;
      cnt_q   <= '0;
    end else begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      whilo_q <= whilo_d;
      hilo_q  <= hilo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_wd    = wd_q;
  assign mem_wreg  = wreg_q;
  assign mem_wdata = wdata_q;
  assign mem_hi    = hi_q;
  assign mem_lo    = lo_q;
  assign mem_whilo = whilo_q;
  assign hilo_o    = hilo_q;
  assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Directed bench for ex_mem: advance, bubble, hold, MADD release,
// flush and reset priority.
module tb_ex_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic        ex_whilo;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [168:0] all_o;
  logic [37:0]  gpr_o;
  assign all_o = {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo,
                  mem_whilo, hilo_o, cnt_o};
  assign gpr_o = {mem_wd, mem_wreg, mem_wdata};

  always #5 clk = ~clk;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
    .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  always @(posedge clk)
    if (!rst && !flush && !stall[3] && stall[4])
      $error("ctrl error: MEM stalled while EX advances");

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [4:0] wd, input logic wreg,
                        input logic [31:0] wdata, input logic [31:0] hi,
                        input logic [31:0] lo, input logic whilo);
    ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
    ex_hi = hi; ex_lo = lo; ex_whilo = whilo;
  endtask

  task automatic test_reset();
    logic [168:0] exp;
    rst = 1'b1; stall = '0; flush = 1'b0;
    set_ex(5'd9, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h2, 1'b1);
    hilo_i = 64'h5; cnt_i = 2'd2;
    tick(); tick();
    exp = '0;
    total_cnt++;
    if (all_o !== exp)
      $display("FAIL reset: got %h want %h", all_o, exp);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_advance();
    logic [168:0] exp;
    stall = 6'b000000;
    set_ex(5'd3, 1'b1, 32'h12345678, 32'hA, 32'hB, 1'b1);
    hilo_i = 64'h77; cnt_i = 2'd1;
    tick();
    exp = {5'd3, 1'b1, 32'h12345678, 32'hA, 32'hB, 1'b1, 64'h0, 2'd0};
    total_cnt++;
    if (all_o !== exp)
      $display("FAIL advance: got %h want %h", all_o, exp);
    else pass_cnt++;
    // bits outside EX/MEM must not matter
    stall = 6'b100111;
    set_ex(5'd31, 1'b0, 32'hCAFE_0001, 32'h3, 32'h4, 1'b0);
    tick();
    exp = {5'd31, 1'b0, 32'hCAFE_0001, 32'h3, 32'h4, 1'b0, 64'h0, 2'd0};
    total_cnt++;
    if (all_o !== exp)
      $display("FAIL advance_ign: got %h want %h", all_o, exp);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    stall = '0;
    for (int i = 0; i < 3; i++) begin
      set_ex(5'(i + 10), 1'b1, 32'h100 + 32'(i), 32'h0, 32'h0, 1'b0);
      tick();
      total_cnt++;
      if (gpr_o !== {5'(i + 10), 1'b1, 32'h100 + 32'(i)})
        $display("FAIL b2b_%0d: got %h want %h", i, gpr_o,
                 {5'(i + 10), 1'b1, 32'h100 + 32'(i)});
      else pass_cnt++;
    end
  endtask

  task automatic test_bubble();
    logic [168:0] exp;
    stall = 6'b001111;
    set_ex(5'd7, 1'b1, 32'h99, 32'h5, 32'h6, 1'b1);
    hilo_i = 64'h1_00000002; cnt_i = 2'd1;
    tick();
    exp = {5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h1_00000002, 2'd1};
    total_cnt++;
    if (all_o !== exp)
      $display("FAIL bubble: got %h want %h", all_o, exp);
    else pass_cnt++;
    stall = 6'b101111;
    hilo_i = 64'hFFFF_0000_1234_5678; cnt_i = 2'b11;
    tick();
    exp = {5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0,
           64'hFFFF_0000_1234_5678, 2'b11};
    total_cnt++;
    if (all_o !== exp)
      $display("FAIL bubble_cnt3: got %h want %h", all_o, exp);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    stall = '0;
    set_ex(5'd3, 1'b1, 32'h12345678, 32'hA, 32'hB, 1'b1);
    cnt_i = 2'd0; hilo_i = '0;
    tick();
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      set_ex(5'(20 + i), 1'b0, 32'hBAD0 + 32'(i), 32'hE, 32'hF, 1'b0);
      cnt_i = 2'(i + 1);
      hilo_i = 64'(i) << 32;
      tick();
      total_cnt++;
      if ({gpr_o, mem_hi, mem_lo, mem_whilo} !==
          {5'd3, 1'b1, 32'h12345678, 32'hA, 32'hB, 1'b1})
        $display("FAIL hold_mem_%0d: got %h want %h", i,
                 {gpr_o, mem_hi, mem_lo, mem_whilo},
                 {5'd3, 1'b1, 32'h12345678, 32'hA, 32'hB, 1'b1});
      else pass_cnt++;
      total_cnt++;
      if ({hilo_o, cnt_o} !== {64'(i) << 32, 2'(i + 1)})
        $display("FAIL hold_acc_%0d: got %h want %h", i,
                 {hilo_o, cnt_o}, {64'(i) << 32, 2'(i + 1)});
      else pass_cnt++;
    end
  endtask

  task automatic test_flush();
    logic [168:0] exp;
    exp = '0;
    stall = 6'b011111; flush = 1'b1;
    hilo_i = 64'h1234; cnt_i = 2'd1;
    tick();
    total_cnt++;
    if (all_o !== exp)
      $display("FAIL flush_hold: got %h want %h", all_o, exp);
    else pass_cnt++;
    flush = 1'b0; stall = '0;
    set_ex(5'd4, 1'b1, 32'h44, 32'h1, 32'h2, 1'b1);
    tick();
    flush = 1'b1;
    set_ex(5'd5, 1'b1, 32'h55, 32'h1, 32'h2, 1'b1);
    tick();
    total_cnt++;
    if (all_o !== exp)
      $display("FAIL flush_adv: got %h want %h", all_o, exp);
    else pass_cnt++;
    flush = 1'b0;
  endtask

  task automatic test_madd_release();
    logic [168:0] exp;
    stall = 6'b001111;
    ex_wreg = 1'b1;
    hilo_i = 64'h1_00000002; cnt_i = 2'd1;
    tick();
    total_cnt++;
    if ({hilo_o, cnt_o} !== {64'h1_00000002, 2'd1})
      $display("FAIL madd_step: got %h want %h", {hilo_o, cnt_o},
               {64'h1_00000002, 2'd1});
    else pass_cnt++;
    stall = '0;
    set_ex(5'd8, 1'b1, 32'h55, 32'h0, 32'h0, 1'b0);
    tick();
    exp = {5'd8, 1'b1, 32'h55, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0};
    total_cnt++;
    if (all_o !== exp)
      $display("FAIL madd_rel: got %h want %h", all_o, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [168:0] exp;
    stall = '0;
    set_ex(5'd6, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0);
    tick();
    total_cnt++;
    if (mem_wdata !== 32'hDEADBEEF)
      $display("FAIL rst_pre: got %h want %h", mem_wdata, 32'hDEADBEEF);
    else pass_cnt++;
    rst = 1'b1; stall = 6'b001111;
    hilo_i = 64'hABCD; cnt_i = 2'd1;
    tick();
    exp = '0;
    total_cnt++;
    if (all_o !== exp)
      $display("FAIL rst_mid: got %h want %h", all_o, exp);
    else pass_cnt++;
    rst = 1'b0; stall = '0;
    set_ex(5'd2, 1'b1, 32'h77, 32'h8, 32'h9, 1'b1);
    tick();
    exp = {5'd2, 1'b1, 32'h77, 32'h8, 32'h9, 1'b1, 64'h0, 2'd0};
    total_cnt++;
    if (all_o !== exp)
      $display("FAIL rst_resume: got %h want %h", all_o, exp);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0;
    set_ex('0, 1'b0, '0, '0, '0, 1'b0);
    hilo_i = '0; cnt_i = '0;
    test_reset();
    test_advance();
    test_back_to_back();
    test_bubble();
    test_hold();
    test_flush();
    test_madd_release();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
